// File: rtl/dmem_responder.sv
// Fixed-latency line memory that answers the data cache's mem_read/mem_write handshake.
// Optional `MEM_STAT_EN adds rd_count, wr_count and busy_cycles statistics outputs.
module dmem_responder #(
  parameter int LATENCY    = 8,
  parameter int ADDR_LSB_W = 8
) (
  input  logic         clk,
  input  logic         proc_reset,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic         mem_ready,
  output logic [127:0] mem_rdata
`ifdef MEM_STAT_EN
  ,
  output logic [31:0]  rd_count,
  output logic [31:0]  wr_count,
  output logic [31:0]  busy_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);
  localparam int         DEPTH    = 1 << ADDR_LSB_W;

  state_t                  state_reg, state_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic                    is_write_reg, is_write_next;
  logic [ADDR_LSB_W-1:0]   index_reg, index_next;
  logic [127:0]            wdata_reg, wdata_next;
  logic [127:0]            mem_rdata_reg;
  logic                    load_rdata;
  logic                    store_line;

  logic [127:0] storage [0:DEPTH-1];

  // Upper line-address bits alias onto the same storage lines.
  logic unused_addr;
  assign unused_addr = ^mem_addr[27:ADDR_LSB_W];

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    is_write_next = is_write_reg;
    index_next    = index_reg;
    wdata_next    = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (mem_read || mem_write) begin
          is_write_next = mem_write;
          index_next    = mem_addr[ADDR_LSB_W-1:0];
          wdata_next    = mem_wdata;
          cnt_next      = CNT_INIT;
          // With unit latency the response follows the accept cycle directly.
          state_next    = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) state_next = RESP;
      end
      RESP:    state_next = GAP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      is_write_reg <= 1'b0;
      index_reg    <= '0;
      wdata_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      is_write_reg <= is_write_next;
      index_reg    <= index_next;
      wdata_reg    <= wdata_next;
    end
  end

  // Read data is fetched on the edge entering RESP so it is valid with mem_ready.
  assign load_rdata = (state_next == RESP) && (state_reg != RESP) && !is_write_next;
  assign store_line = (state_reg == RESP) && is_write_reg;

  always_ff @(posedge clk) begin
    if (store_line) storage[index_reg] <= wdata_reg;
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) mem_rdata_reg <= '0;
    else if (load_rdata) mem_rdata_reg <= storage[index_next];
  end

  assign mem_ready = (state_reg == RESP);
  assign mem_rdata = mem_rdata_reg;

`ifdef MEM_STAT_EN
  logic [2:0] stat_inc;
  assign stat_inc = {state_reg != IDLE,
                     (state_reg == RESP) && is_write_reg,
                     (state_reg == RESP) && !is_write_reg};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      logic [31:0] stat_reg;
      always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) stat_reg <= '0;
        else if (stat_inc[gi] && (stat_reg != 32'hFFFF_FFFF)) stat_reg <= stat_reg + 32'd1;
      end
    end
  endgenerate

  assign rd_count    = g_stat[0].stat_reg;
  assign wr_count    = g_stat[1].stat_reg;
  assign busy_cycles = g_stat[2].stat_reg;
`endif

endmodule
